// File: rtl/vdcram_arb_pkg.sv
// vdc_ram_pkg: shared constants, types and helpers for the VDC multi-requester
// video RAM.
//   VDC_FOLD_BIT  - first address bit that is forced to zero in 16K mode
//   MAX_CHANNELS  - upper limit on the number of requesters
//   chan_idx_t    - wide enough to index any legal channel
//   onehot_first  - round-robin search: the first set request at or above ptr,
//                   wrapping at n
package vdc_ram_pkg;

    localparam int VDC_FOLD_BIT = 14;
    localparam int MAX_CHANNELS = 8;

    typedef logic [$clog2(MAX_CHANNELS)-1:0] chan_idx_t;

    // Returns a one-hot vector marking the first requesting channel found when
    // scanning upward from ptr over channels 0..n-1, wrapping past n-1.
    // ptr must be below n. The loop has a fixed trip count so that it unrolls
    // into plain priority logic.
    function automatic logic [MAX_CHANNELS-1:0] onehot_first(
        input logic [MAX_CHANNELS-1:0] req,
        input chan_idx_t               ptr,
        input int                      n
    );
        logic [MAX_CHANNELS-1:0] g;
        logic                    found;
        int                      idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !found && idx < MAX_CHANNELS) begin
                if (req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/vdcram_arb_if.sv
// vdcram_arb_if: bundle of requester-side signals for vdcram_arb.
//   ram64k  - 1 = full addressing, 0 = 16K folding
//   req/we  - per-channel request level and write enable
//   addr    - packed per-channel addresses (channel i in slice i)
//   dai     - packed per-channel write data
//   ack     - one-hot grant pulse
//   dao     - shared registered read data
//   rvalid  - one-hot owner tag for dao
// The master modport is the requester side; the slave modport is the RAM side.
interface vdcram_arb_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int CHANNELS      = 3
);
    logic                               ram64k;
    logic [CHANNELS-1:0]                req;
    logic [CHANNELS-1:0]                we;
    logic [CHANNELS*ADDRESS_WIDTH-1:0]  addr;
    logic [CHANNELS*DATA_WIDTH-1:0]     dai;
    logic [CHANNELS-1:0]                ack;
    logic [DATA_WIDTH-1:0]              dao;
    logic [CHANNELS-1:0]                rvalid;

    modport master (
        output ram64k, req, we, addr, dai,
        input  ack, dao, rvalid
    );

    modport slave (
        input  ram64k, req, we, addr, dai,
        output ack, dao, rvalid
    );
endinterface

// File: rtl/vdcram_arb_bank.sv
// vdcram_bank: single-port synchronous RAM with a registered read port.
//   clk  - clock
//   en   - access enable (one access per cycle)
//   we   - write when en is high, otherwise read
//   addr - word address
//   din  - write data
//   dout - registered data; on a write it carries the newly written word
// There is no reset: the contents and the read register survive reset so that
// the array maps onto block RAM.
module vdcram_bank #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout
);
    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDRESS_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout      <= din;
            end else begin
                dout      <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/vdcram_arb.sv
// vdcram_arb: VDC video RAM shared by CHANNELS requesters.
//   clk     - clock
//   reset_n - asynchronous active-low reset; the array contents are kept
//   bus     - vdcram_arb_if.slave (ram64k, req, we, addr, dai in;
//             ack, dao, rvalid out)
// Each cycle one requester is granted, either by channel-0 priority (PRIO0=1)
// or by round-robin. The grant drives the bank in the same cycle. ack is the
// registered grant. A granted read returns dao with a one-hot rvalid tag one
// cycle after its ack.
module vdcram_arb
    import vdc_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int CHANNELS      = 3,
    parameter int PRIO0         = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    vdcram_arb_if.slave   bus
);
    generate
        if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
            $error("vdcram_arb: CHANNELS must be within 1..8");
        end
    endgenerate

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // 16K mode keeps only the low VDC_FOLD_BIT address bits.
    localparam logic [ADDRESS_WIDTH-1:0] FOLD_MASK =
        (ADDRESS_WIDTH > VDC_FOLD_BIT) ? ADDRESS_WIDTH'((1 << VDC_FOLD_BIT) - 1)
                                       : {ADDRESS_WIDTH{1'b1}};

    logic [MAX_CHANNELS-1:0]  req_ext;
    logic [MAX_CHANNELS-1:0]  grant_ext;
    logic [CHANNELS-1:0]      grant;
    logic                     prio_hit;
    logic [CW-1:0]            gnt_idx;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [ADDRESS_WIDTH-1:0] bank_addr;
    logic [DATA_WIDTH-1:0]    sel_dai;
    logic                     sel_we;
    logic                     bank_en;
    logic [DATA_WIDTH-1:0]    bank_dout;

    logic [CW-1:0]            rr_ptr_reg;
    logic [CHANNELS-1:0]      ack_reg;
    logic [CHANNELS-1:0]      rd_tag_reg;
    logic [CHANNELS-1:0]      rvalid_reg;
    logic [DATA_WIDTH-1:0]    dao_reg;

    // Arbitration
    always_comb begin
        req_ext                 = '0;
        req_ext[CHANNELS-1:0]   = bus.req;
        prio_hit                = (PRIO0 != 0) && bus.req[0];
        if (prio_hit) begin
            grant_ext    = '0;
            grant_ext[0] = 1'b1;
        end else begin
            grant_ext = onehot_first(req_ext, chan_idx_t'(rr_ptr_reg), CHANNELS);
        end
        grant = grant_ext[CHANNELS-1:0];

        gnt_idx = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (grant_ext[i]) begin
                gnt_idx = CW'(i);
            end
        end
    end

    // Select the granted channel's request.
    // The AND-OR form is valid because the grant is one-hot.
    always_comb begin
        sel_addr = '0;
        sel_dai  = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_ext[i]) begin
                sel_addr = sel_addr | bus.addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_dai  = sel_dai  | bus.dai[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we   = sel_we   | bus.we[i];
            end
        end
        bank_addr = bus.ram64k ? sel_addr : (sel_addr & FOLD_MASK);
        // Requests seen during reset are not acked, so they must not reach
        // the array either.
        bank_en   = (|grant) && reset_n;
    end

    vdcram_bank #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .we   (sel_we),
        .addr (bank_addr),
        .din  (sel_dai),
        .dout (bank_dout)
    );

    // ack is the registered grant.
    // The bank read register fills at the ack edge. One more stage moves the
    // word into dao, so rvalid lines up one cycle after ack. Writes leave dao
    // alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
            ack_reg    <= '0;
            rd_tag_reg <= '0;
            rvalid_reg <= '0;
            dao_reg    <= '0;
        end else begin
            ack_reg    <= grant;
            rd_tag_reg <= sel_we ? '0 : grant;
            rvalid_reg <= rd_tag_reg;
            if (|rd_tag_reg) begin
                dao_reg <= bank_dout;
            end
            if ((|grant) && !prio_hit) begin
                rr_ptr_reg <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign bus.ack    = ack_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.dao    = dao_reg;
endmodule

// File: tb/tb_vdcram_arb.sv
// Testbench for vdcram_arb.
// Two instances see the same stimulus: dut_p uses channel-0 priority and dut_r
// uses pure round-robin. A per-instance reference model predicts every ack,
// rvalid and dao. It applies the arbitration rules directly with modular
// arithmetic and keeps a flat memory image.
module tb_vdcram_arb;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    req_v = '0;
    logic [NC-1:0]    we_v = '0;
    logic [NC*AW-1:0] addr_v = '0;
    logic [NC*DW-1:0] dai_v = '0;
    logic             ram64k_v = 1'b1;

    vdcram_arb_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CHANNELS(NC)) bus_p ();
    vdcram_arb_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CHANNELS(NC)) bus_r ();

    assign bus_p.req = req_v;  assign bus_r.req = req_v;
    assign bus_p.we = we_v;    assign bus_r.we = we_v;
    assign bus_p.addr = addr_v; assign bus_r.addr = addr_v;
    assign bus_p.dai = dai_v;  assign bus_r.dai = dai_v;
    assign bus_p.ram64k = ram64k_v; assign bus_r.ram64k = ram64k_v;

    vdcram_arb #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CHANNELS(NC), .PRIO0(1)) dut_p (
        .clk(clk), .reset_n(reset_n), .bus(bus_p));
    vdcram_arb #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CHANNELS(NC), .PRIO0(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(bus_r));

    int errors = 0;
    int checks = 0;

    // Reference model state; index 0 models dut_p and index 1 models dut_r.
    int         ptr_m [2];
    logic [7:0] mem_m [2][65536];
    bit         known_m [2][65536];
    logic [2:0] pend_rv [2];
    logic [7:0] pend_dao [2];
    bit         pend_known [2];
    logic [7:0] exp_dao [2];
    bit         exp_known [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input bit r, input bit w,
                          input logic [15:0] a, input logic [7:0] d);
        req_v[i]          = r;
        we_v[i]           = w;
        addr_v[i*AW +: AW] = a;
        dai_v[i*DW +: DW]  = d;
    endtask

    task automatic idle_inputs();
        req_v = '0;
        we_v  = '0;
    endtask

    // Runs one clock cycle with the current inputs. It predicts the grant for
    // both instances, then checks ack, rvalid and dao just after the edge.
    task automatic tick();
        int         g [2];
        logic [2:0] nrv [2];
        logic [7:0] ndao [2];
        bit         nknown [2];
        logic [15:0] fa;
        logic [2:0] obs_ack, obs_rv;
        logic [7:0] obs_dao;
        for (int d = 0; d < 2; d++) begin
            g[d]      = -1;
            nrv[d]    = '0;
            ndao[d]   = '0;
            nknown[d] = 1'b0;
            if (d == 0 && req_v[0]) begin
                g[d] = 0;
            end else begin
                for (int k = 0; k < NC; k++) begin
                    if (g[d] < 0 && req_v[(ptr_m[d] + k) % NC]) g[d] = (ptr_m[d] + k) % NC;
                end
                if (g[d] >= 0) ptr_m[d] = (g[d] + 1) % NC;
            end
            if (g[d] >= 0) begin
                fa = addr_v[g[d]*AW +: AW];
                if (!ram64k_v) fa[15:14] = 2'b00;
                if (we_v[g[d]]) begin
                    mem_m[d][fa]   = dai_v[g[d]*DW +: DW];
                    known_m[d][fa] = 1'b1;
                end else begin
                    nrv[d]    = 3'(1 << g[d]);
                    ndao[d]   = mem_m[d][fa];
                    nknown[d] = known_m[d][fa];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            obs_ack = (d == 0) ? bus_p.ack : bus_r.ack;
            obs_rv  = (d == 0) ? bus_p.rvalid : bus_r.rvalid;
            obs_dao = (d == 0) ? bus_p.dao : bus_r.dao;
            chk(d == 0 ? "ack_p" : "ack_r", 32'(obs_ack), (g[d] >= 0) ? 32'(1 << g[d]) : 32'd0);
            chk(d == 0 ? "rvalid_p" : "rvalid_r", 32'(obs_rv), 32'(pend_rv[d]));
            if (pend_rv[d] != 0) begin
                exp_dao[d]   = pend_dao[d];
                exp_known[d] = pend_known[d];
            end
            if (exp_known[d]) chk(d == 0 ? "dao_p" : "dao_r", 32'(obs_dao), 32'(exp_dao[d]));
            pend_rv[d]    = nrv[d];
            pend_dao[d]   = ndao[d];
            pend_known[d] = nknown[d];
        end
        $display("cycle t=%0t req=%b we=%b ram64k=%b | p: ack=%b rv=%b dao=%h | r: ack=%b rv=%b dao=%h",
                 $time, req_v, we_v, ram64k_v, bus_p.ack, bus_p.rvalid, bus_p.dao,
                 bus_r.ack, bus_r.rvalid, bus_r.dao);
    endtask

    // Drops reset mid-cycle and checks the cleared outputs while reset is
    // held. It releases reset away from the edge and leaves the bench just
    // after a clock edge.
    task automatic do_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            ptr_m[d]     = 0;
            pend_rv[d]   = '0;
            exp_dao[d]   = '0;
            exp_known[d] = 1'b1;
        end
        chk("rst_ack_p", 32'(bus_p.ack), 32'd0);
        chk("rst_rvalid_p", 32'(bus_p.rvalid), 32'd0);
        chk("rst_dao_p", 32'(bus_p.dao), 32'd0);
        chk("rst_ack_r", 32'(bus_r.ack), 32'd0);
        chk("rst_rvalid_r", 32'(bus_r.rvalid), 32'd0);
        chk("rst_dao_r", 32'(bus_r.dao), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend_known[d] = 1'b0;
            pend_dao[d]   = '0;
            for (int a = 0; a < 65536; a++) begin
                mem_m[d][a]   = '0;
                known_m[d][a] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        do_reset();

        // Basic write then read on channel 1.
        idle_inputs();
        set_ch(1, 1, 1, 16'h1234, 8'hA5);
        tick();
        chk("wr_ack_p", 32'(bus_p.ack), 32'b010);
        set_ch(1, 1, 0, 16'h1234, 8'h00);
        tick();
        chk("rd_ack_r", 32'(bus_r.ack), 32'b010);
        idle_inputs();
        tick();
        chk("rd_rvalid_p", 32'(bus_p.rvalid), 32'b010);
        chk("rd_dao_p", 32'(bus_p.dao), 32'hA5);
        chk("rd_dao_r", 32'(bus_r.dao), 32'hA5);

        // Channel-0 priority under full contention.
        set_ch(0, 1, 0, 16'h1234, 8'h00);
        set_ch(1, 1, 0, 16'h0100, 8'h00);
        set_ch(2, 1, 0, 16'h0200, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("prio_ack_p", 32'(bus_p.ack), 32'b001);
        end
        idle_inputs();
        tick();
        tick();

        // Round-robin order from a fresh pointer.
        do_reset();
        set_ch(0, 1, 0, 16'h1234, 8'h00);
        set_ch(1, 1, 0, 16'h0100, 8'h00);
        set_ch(2, 1, 0, 16'h0200, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_order_r", 32'(bus_r.ack), 32'(1 << (k % 3)));
        end
        idle_inputs();
        tick();
        chk("rr_rvalid_r", 32'(bus_r.rvalid), 32'b001);
        tick();

        // 16K folding and full 64K addressing.
        ram64k_v = 1'b0;
        set_ch(2, 1, 1, 16'h4123, 8'h5A);
        tick();
        set_ch(2, 1, 0, 16'h0123, 8'h00);
        tick();
        idle_inputs();
        tick();
        chk("fold16k_dao_r", 32'(bus_r.dao), 32'h5A);
        ram64k_v = 1'b1;
        set_ch(2, 1, 1, 16'hC123, 8'h77);
        tick();
        set_ch(2, 1, 0, 16'h0123, 8'h00);
        tick();
        set_ch(2, 1, 0, 16'hC123, 8'h00);
        tick();
        chk("alias_kept_dao_p", 32'(bus_p.dao), 32'h5A);
        idle_inputs();
        tick();
        chk("full64k_dao_p", 32'(bus_p.dao), 32'h77);

        // Read of a word written in the previous cycle.
        set_ch(0, 1, 1, 16'h0010, 8'h11);
        tick();
        set_ch(0, 1, 0, 16'h0010, 8'h00);
        tick();
        idle_inputs();
        tick();
        chk("raw_dao_r", 32'(bus_r.dao), 32'h11);
        chk("raw_rvalid_r", 32'(bus_r.rvalid), 32'b001);

        // A read acked just before reset gets no rvalid.
        // The array survives the reset.
        set_ch(1, 1, 0, 16'h1234, 8'h00);
        tick();
        do_reset();
        chk("rst_kill_rvalid_p", 32'(bus_p.rvalid), 32'd0);
        set_ch(1, 1, 0, 16'h1234, 8'h00);
        tick();
        idle_inputs();
        tick();
        chk("preserved_dao_p", 32'(bus_p.dao), 32'hA5);
        chk("preserved_dao_r", 32'(bus_r.dao), 32'hA5);

        // Random traffic on a small address set that spans the fold bits.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NC; i++) begin
                set_ch(i, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                       16'(($urandom_range(0, 3) << 14) | $urandom_range(0, 15)),
                       8'($urandom));
            end
            ram64k_v = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vdcram_arb.md
Name: vdcram_arb

Overview:
- Parametrised successor to the VDC single-port video RAM: owns the RAM array and serves CHANNELS independent requesters (display fetch, CPU register port, block copy/fill engine) through a req/ack handshake.
- Arbitrates one access per clock, using round-robin or channel-0 priority.
- Registers read data and returns it with a one-hot rvalid tag.
- Applies VDC 16K/64K address folding at runtime.

Parameters:
- DATA_WIDTH, 8: word width.
- ADDRESS_WIDTH, 16: address width; array depth is 2**ADDRESS_WIDTH.
- CHANNELS, 3: requester count, 1..8.
- PRIO0, 1: 1 = channel 0 always wins; 0 = pure round-robin over all channels.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ram64k  in  1  1 = full address; 0 = 16K mode, addr[ADDRESS_WIDTH-1:14] forced to 0 (only when ADDRESS_WIDTH>14).
- req  in  CHANNELS  per-channel request level.
- we  in  CHANNELS  per-channel write enable, qualified by req.
- addr  in  CHANNELS*ADDRESS_WIDTH  packed addresses; channel i in slice i.
- dai  in  CHANNELS*DATA_WIDTH  packed write data.
- ack  out  CHANNELS  one-hot grant pulse.
- dao  out  DATA_WIDTH  shared registered read data.
- rvalid  out  CHANNELS  one-hot; marks the owner of dao.

Behaviour:
- Reset (async assert, sync release): ack=0, rvalid=0, dao=0, rr_ptr=0.
  - A read granted in the cycle before reset gets no rvalid.
  - Array contents are preserved, not cleared.
- Handshake:
  - Requester raises req with addr/we/dai stable and holds them until ack=1.
  - ack is a 1-cycle pulse in the cycle the access is committed (combinational grant, registered ack: ack goes high in cycle N+1 after req is sampled in cycle N).
  - Requester drops req or presents a new request in the cycle after ack.
  - A req still high in the cycle after ack is treated as a new request.
- Arbitration per cycle:
  - At most one grant.
  - PRIO0=1 and req[0]=1 -> grant channel 0, rr_ptr unchanged.
  - Otherwise grant the first requesting channel searching from rr_ptr upward with wrap; then rr_ptr = granted+1 (wraps CHANNELS-1 -> 0).
  - No request -> no grant, rr_ptr unchanged.
- Access timing:
  - Granted write updates the array at the ack edge.
  - Granted read: dao and rvalid[i] are valid in the cycle after ack[i] (latency 2 from req sampling).
  - Pipelining: back-to-back grants every cycle; throughput 1 access/clk.
- Write grants produce no rvalid; dao holds its previous value.
- Read of an address written in the immediately preceding cycle returns the new data.
- Address folding:
  - Applied before the array, to both reads and writes.
  - In 16K mode, 0x4123 and 0x0123 alias.
  - ram64k may change at any cycle and takes effect on the next grant.
- Starvation bound:
  - PRIO0=0: any held req is acked within CHANNELS cycles.
  - PRIO0=1: the bound holds only while channel 0 is idle at least 1 cycle in CHANNELS.
- Out-of-range CHANNELS: elaboration error.

Decomposition:
- Package vdc_ram_pkg:
  - VDC_FOLD_BIT = 14.
  - Function onehot_first(req, ptr) for round-robin search.
  - Typedef for channel index (clog2 CHANNELS).
- Sub-module vdcram_bank: single-port synchronous RAM (we, addr, dai, registered dao, new-data read-during-write), behavioural array so it infers block RAM.
- vdcram_arb owns arbitration, folding, output mux and rvalid tagging.

Test Plan:
- Reset, then ch1 writes 0xA5 to 0x1234, ch1 reads 0x1234 -> ack[1] each time; rvalid=3'b010 with dao=0xA5 one cycle after the read ack.
- PRIO0=1, req=3'b111 held for 4 cycles -> ack[0] every cycle, no grants to ch1/ch2.
- PRIO0=0, all three hold read requests -> ack order 0,1,2,0; rvalid follows one cycle later, same order.
- ram64k=0: write 0x5A to 0x4123, then read 0x0123 -> 0x5A. ram64k=1: write 0x77 to 0xC123 -> read 0x0123 still 0x5A, read 0xC123 = 0x77.
- Write 0x11 to 0x0010 at cycle N, read 0x0010 granted at N+1 -> dao=0x11 at N+2.
- Read granted, reset_n low the next cycle -> rvalid stays 0. After release, read of a previously written location returns the old data (array preserved).
